ins_fetch_queue: RTL and testbench
==================================

// Module: ins_fetch_queue
// PURPOSE
//  Instruction fetch unit directly downstream of the instruction cache. Owns the fetch PC and
//  presents it to the ICache each cycle. Enqueues each returned word with its PC and a static
//  next-PC prediction into an instruction queue. The decoder drains the queue; the ROB/branch
//  unit redirects the PC on mispredict.
// PARAMETERS
//  QUEUE_DEPTH  8      entries in instruction queue; power of 2, >=2
//  RESET_PC     32'h0  fetch PC after reset
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  rdy            in   1   global ready; 0 freezes all state
//  fetch_enable   out  1   to ICache: request word at pc (combinational)
//  pc             out  32  to ICache: current fetch PC (registered)
//  hit            in   1   from ICache: hit_data is valid for pc this cycle
//  hit_data       in   32  from ICache: instruction word
//  iq_valid       out  1   head entry present (count != 0)
//  iq_inst        out  32  head instruction
//  iq_pc          out  32  head instruction PC
//  iq_pred_taken  out  1   head predicted taken
//  iq_pred_pc     out  32  head predicted next PC
//  iq_ready       in   1   decoder consumes head this cycle
//  flush          in   1   redirect: discard queue, restart at flush_pc
//  flush_pc       in   32  redirect target
//  iq_full        out  1   count == QUEUE_DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0, async): pc=RESET_PC, head=tail=0, count=0.
//    Outputs: iq_valid=0, iq_full=0, fetch_enable=0. Entry storage is not reset.
//  - fetch_enable = rst_n & rdy & ~flush & ~iq_full.
//  - hit may be asserted while fetch_enable=0 (ICache refill path), so:
//    accept = fetch_enable & hit. Unqualified hit is ignored.
//  - Accept (rdy=1, no flush): write {hit_data, pc, pred_taken, pred_pc} at tail.
//    Then tail++, count++, pc<=pred_pc.
//  - Prediction, computed from hit_data in the accept cycle (32-bit add, wraps mod 2^32):
//      opcode 1101111 (JAL): taken; pred_pc = pc + sext(J-imm).
//      opcode 1100011 (branch) with inst[31]=1 (backward): taken; pred_pc = pc + sext(B-imm).
//      all others, incl. forward branch and JALR: not taken; pred_pc = pc + 4.
//  - Dequeue: iq_valid & iq_ready & rdy -> head++, count--.
//  - Simultaneous accept + dequeue: count unchanged, both pointers advance.
//  - Full: enqueue is blocked even if a dequeue occurs the same cycle. iq_full is based on the
//    registered count, with no fall-through.
//  - Empty: an entry enqueued this cycle is visible on iq_* next cycle (latency 1, no bypass).
//    iq_* outputs are don't-care while iq_valid=0.
//  - Pointers are log2(QUEUE_DEPTH) bits and wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.
//  - Flush (rdy=1) has priority over accept and dequeue: head=tail=count=0, pc<=flush_pc.
//    Any hit in the flush cycle is dropped. Fetching resumes at flush_pc the next cycle.
//  - rdy=0: no state change. flush/iq_ready/hit are ignored; the sender holds them.
//  - Reset asserted mid-operation: immediate return to reset values; queue contents are lost.
// TESTING
//  1 rst_n=0 -> pc=0, iq_valid=0, fetch_enable=0.
//    Release with rdy=1, hit=0 -> fetch_enable=1, pc stays 0.
//  2 hit=1 for 8 cycles with addi words, iq_ready=0 -> pc 0,4,..,0x1C then 0x20.
//    iq_full=1, fetch_enable=0; a 9th hit is not enqueued.
//  3 JAL 0x1000006F accepted at pc=0x10 -> pc=0x110.
//    Entry: iq_pred_taken=1, iq_pred_pc=0x110.
//  4 BEQ 0xFE000CE3 at pc=0x20 -> pc=0x18, pred_taken=1.
//    BNE +8 (0x00101463) at 0x18 -> pc=0x1C, pred_taken=0.
//  5 Queue holds 3 entries; flush=1, flush_pc=0x200, hit=1 in the same cycle.
//    Next cycle: iq_valid=0, count=0, pc=0x200, hit word absent.
//  6 Full queue; iq_ready=1 and hit=1 in the same cycle -> count=7, head advances, pc unchanged.
//    Repeat with rdy=0 -> nothing changes.

Source files
------------

// File: rtl/ins_fetch_queue.sv
// Fetch unit: owns the fetch PC and queues returned ICache words with a static next-PC prediction.
// JAL and backward branches predict taken; everything else falls through to pc + 4.
module ins_fetch_queue #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic        fetch_enable,
  output logic [31:0] pc,
  input  logic        hit,
  input  logic [31:0] hit_data,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_pred_taken,
  output logic [31:0] iq_pred_pc,
  input  logic        iq_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        iq_full
);

  localparam int                PTR_W      = $clog2(QUEUE_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [6:0]        OP_JAL     = 7'b1101111;
  localparam logic [6:0]        OP_BRANCH  = 7'b1100011;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0] inst_mem  [QUEUE_DEPTH];
  logic [31:0] pc_mem    [QUEUE_DEPTH];
  logic        taken_mem [QUEUE_DEPTH];
  logic [31:0] pred_mem  [QUEUE_DEPTH];

  logic        accept;
  logic        dequeue;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign iq_valid     = (count != '0);
  assign iq_full      = (count == FULL_COUNT);
  assign fetch_enable = rst_n & rdy & ~flush & ~iq_full;
  // A hit while fetch_enable is low belongs to the refill path and must not be queued.
  assign accept       = fetch_enable & hit;
  assign dequeue      = iq_valid & iq_ready & rdy & ~flush;

  assign j_imm = {{12{hit_data[31]}}, hit_data[19:12], hit_data[20], hit_data[30:21], 1'b0};
  assign b_imm = {{20{hit_data[31]}}, hit_data[7], hit_data[30:25], hit_data[11:8], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc + 32'd4;
    if (hit_data[6:0] == OP_JAL) begin
      pred_taken = 1'b1;
      pred_pc    = pc + j_imm;
    end else if (hit_data[6:0] == OP_BRANCH && hit_data[31]) begin
      pred_taken = 1'b1;
      pred_pc    = pc + b_imm;
    end
  end

  // Entry storage carries no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      inst_mem[tail]  <= hit_data;
      pc_mem[tail]    <= pc;
      taken_mem[tail] <= pred_taken;
      pred_mem[tail]  <= pred_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        pc    <= flush_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (accept) begin
          tail <= tail + PTR_W'(1);
          pc   <= pred_pc;
        end
        if (dequeue) begin
          head <= head + PTR_W'(1);
        end
        count <= count + CNT_W'(accept) - CNT_W'(dequeue);
      end
    end
  end

  assign iq_inst       = inst_mem[head];
  assign iq_pc         = pc_mem[head];
  assign iq_pred_taken = taken_mem[head];
  assign iq_pred_pc    = pred_mem[head];

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue; a queue of expected entries tracks what the decoder should see.
module tb_ins_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        fetch_enable;
  logic [31:0] pc;
  logic        hit;
  logic [31:0] hit_data;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_taken;
  logic [31:0] iq_pred_pc;
  logic        iq_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        iq_full;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] pred;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] model_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ins_fetch_queue #(.QUEUE_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .fetch_enable (fetch_enable),
    .pc           (pc),
    .hit          (hit),
    .hit_data     (hit_data),
    .iq_valid     (iq_valid),
    .iq_inst      (iq_inst),
    .iq_pc        (iq_pc),
    .iq_pred_taken(iq_pred_taken),
    .iq_pred_pc   (iq_pred_pc),
    .iq_ready     (iq_ready),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .iq_full      (iq_full)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Compare registered outputs and the queue head against the scoreboard.
  task automatic checkOutput(input string step);
    checkValue({step, " pc"}, pc, model_pc);
    checkValue({step, " iq_valid"}, iq_valid, exp_q.size() != 0);
    checkValue({step, " iq_full"}, iq_full, exp_q.size() == 8);
    if (exp_q.size() != 0) begin
      checkValue({step, " iq_inst"}, iq_inst, exp_q[0].inst);
      checkValue({step, " iq_pc"}, iq_pc, exp_q[0].pc);
      checkValue({step, " iq_pred_taken"}, iq_pred_taken, exp_q[0].taken);
      checkValue({step, " iq_pred_pc"}, iq_pred_pc, exp_q[0].pred);
    end
  endtask

  // One clock of stimulus; exp_taken/exp_pred describe the word if it gets accepted.
  task automatic applyStimulus(input string step, input logic h, input logic [31:0] d,
                               input logic rd, input logic ready, input logic fl,
                               input logic [31:0] fpc, input logic exp_taken,
                               input logic [31:0] exp_pred);
    logic exp_fe;
    logic do_deq;
    hit      = h;
    hit_data = d;
    rdy      = rd;
    iq_ready = ready;
    flush    = fl;
    flush_pc = fpc;
    #1;
    exp_fe = rd & ~fl & (exp_q.size() != 8);
    checkValue({step, " fetch_enable"}, fetch_enable, exp_fe);
    if (rd) begin
      if (fl) begin
        exp_q.delete();
        model_pc = fpc;
      end else begin
        do_deq = ready && (exp_q.size() != 0);
        if (exp_fe && h) begin
          exp_q.push_back('{d, model_pc, exp_taken, exp_pred});
          model_pc = exp_pred;
        end
        if (do_deq) void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    checkOutput(step);
  endtask

  initial begin
    rst_n    = 1'b0;
    rdy      = 1'b0;
    hit      = 1'b0;
    hit_data = '0;
    iq_ready = 1'b0;
    flush    = 1'b0;
    flush_pc = '0;
    model_pc = 32'h0;

    #3;
    checkValue("reset pc", pc, 32'h0);
    checkValue("reset iq_valid", iq_valid, 1'b0);
    checkValue("reset iq_full", iq_full, 1'b0);
    checkValue("reset fetch_enable", fetch_enable, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("release", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Fill the queue with addi words, decoder stalled.
    for (int i = 0; i < 8; i++) begin
      applyStimulus("fill", 1'b1, 32'h00000093 | (i << 20), 1'b1, 1'b0, 1'b0, 32'h0,
                    1'b0, model_pc + 32'd4);
    end
    checkValue("fill pc const", pc, 32'h20);
    applyStimulus("ninth hit", 1'b1, 32'h00900093, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h24);
    applyStimulus("rdy0 full", 1'b1, 32'h00a00093, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h24);
    applyStimulus("full deq", 1'b1, 32'h00b00093, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h24);
    checkValue("full deq pc const", pc, 32'h20);
    for (int i = 0; i < 7; i++) begin
      applyStimulus("drain", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    // JAL prediction.
    applyStimulus("flush 0x10", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    applyStimulus("jal", 1'b1, 32'h1000006F, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h110);
    checkValue("jal pc const", pc, 32'h110);

    // Backward branch taken, forward branch and JALR fall through.
    applyStimulus("flush 0x20", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    applyStimulus("beq back", 1'b1, 32'hFE000CE3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h18);
    applyStimulus("bne fwd", 1'b1, 32'h00101463, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1C);
    applyStimulus("jalr", 1'b1, 32'h000080E7, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20);
    checkValue("jalr pc const", pc, 32'h20);

    // Backward JAL from 0 wraps the PC, then pc + 4 wraps back to 0.
    applyStimulus("flush 0x0", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    applyStimulus("jal wrap", 1'b1, 32'hFFDFF06F, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC);
    applyStimulus("add wrap", 1'b1, 32'h00100093, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("third", 1'b1, 32'h00200093, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4);

    // Flush with a concurrent hit: ignored while rdy=0, then wins over the hit.
    applyStimulus("flush rdy0", 1'b1, 32'h00300093, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    applyStimulus("flush hit", 1'b1, 32'h00300093, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    checkValue("flush pc const", pc, 32'h200);
    applyStimulus("post flush", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of operation.
    applyStimulus("pre rst a", 1'b1, 32'h00400093, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h204);
    applyStimulus("pre rst b", 1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h208);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_pc = 32'h0;
    checkValue("async rst pc", pc, 32'h0);
    checkValue("async rst iq_valid", iq_valid, 1'b0);
    checkValue("async rst fetch_enable", fetch_enable, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("after rst", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
